alu_result_tx: RTL and testbench

- Output-side counterpart to the ALU input control path.
- On a request pulse, captures the ALU result and its overflow and zero flags into one frame byte.
- Serializes that byte on a UART TX line (8N1 by default) so a host can read back ALU results.
- Sits beside the ALU in the top level; its capture inputs are driven from the ALU outputs.

---
 rtl/alu_result_tx.sv | 185 ++++++++++++++++++
 tb/tb_alu_result_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// ALU result reporter: captures {zero, overflow, result} into one byte and sends it as a UART frame.
// Define ALU_RESULT_TX_PARITY_EN to append an even-parity bit after the data bits.
module alu_result_tx #(
    parameter int N        = 5,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int OVS      = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_alu_Result,
    input  logic         i_overflow_Flag,
    input  logic         i_zero_Flag,
    input  logic         i_send,
    output logic         o_tx,
    output logic         o_tx_busy,
    output logic         o_tx_done,
    output logic [2:0]   o_state
);

    // Handshake: i_send is a level sampled every clock; it is accepted only in IDLE,
    // where o_tx_busy is low. o_tx_done pulses for one cycle as o_tx_busy falls.

    if (N + 2 > DBIT) begin : g_chk_width
        $error("alu_result_tx: N+2 must not exceed DBIT");
    end
    if (BAUD_DIV < 2) begin : g_chk_baud
        $error("alu_result_tx: BAUD_DIV must be at least 2");
    end

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int BW   = $clog2(BAUD_DIV);
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] OVS_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] DBIT_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;
    logic [DBIT-1:0] frame;
    logic            tick;
    logic            tx;
    logic            busy;
    logic            done;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic            par;
`endif

    always_comb begin
        frame         = '0;
        frame[N-1:0]  = i_alu_Result;
        frame[DBIT-2] = i_overflow_Flag;
        frame[DBIT-1] = i_zero_Flag;
    end

    assign tick = (state != IDLE) && (baud_cnt == BAUD_LAST);

    // Held at zero in IDLE so the first bit of a frame gets full length.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            baud_cnt <= '0;
        end else if (state == IDLE || baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_send) begin
                        shreg <= frame;
                        state <= START;
                        busy  <= 1'b1;
                        tx    <= 1'b0;
                        s     <= '0;
                        n     <= '0;
`ifdef ALU_RESULT_TX_PARITY_EN
                        par   <= ^frame;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == OVS_LAST) begin
                            state <= DATA;
                            s     <= '0;
                            n     <= '0;
                            tx    <= shreg[0];
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == OVS_LAST) begin
                            s     <= '0;
                            shreg <= shreg >> 1;
                            if (n == DBIT_LAST) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= par;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                n  <= n + NW'(1);
                                tx <= shreg[1];
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
`ifdef ALU_RESULT_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s == OVS_LAST) begin
                            state <= STOP;
                            s     <= '0;
                            tx    <= 1'b1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s == SB_LAST) begin
                            state <= IDLE;
                            s     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx      = tx;
    assign o_tx_busy = busy;
    assign o_tx_done = done;
    assign o_state   = state;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: random ALU results are framed by a byte-level model and the
// serial line is decoded at bit centres and timed against the frame-length formula.
module tb_alu_result_tx;

    localparam int N        = 5;
    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int OVS      = 16;
    localparam int BAUD_DIV = 2;
    localparam int BIT      = OVS * BAUD_DIV;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int FRAME_LEN = (2 + DBIT) * BIT + SB_TICK * BAUD_DIV;
`else
    localparam int FRAME_LEN = (1 + DBIT) * BIT + SB_TICK * BAUD_DIV;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] alu_result = '0;
    logic         ovf = 1'b0;
    logic         zero = 1'b0;
    logic         send = 1'b0;
    logic         tx;
    logic         busy;
    logic         done;
    logic [2:0]   state;

    alu_result_tx #(
        .N(N), .DBIT(DBIT), .SB_TICK(SB_TICK), .OVS(OVS), .BAUD_DIV(BAUD_DIV)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_alu_Result(alu_result),
        .i_overflow_Flag(ovf),
        .i_zero_Flag(zero),
        .i_send(send),
        .o_tx(tx),
        .o_tx_busy(busy),
        .o_tx_done(done),
        .o_state(state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx === 1'b0) low_cnt <= low_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [DBIT-1:0] exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DBIT-1:0] model_byte(input logic [N-1:0] r, input logic o, input logic z);
        int v;
        v = int'(z) * 128 + int'(o) * 64 + int'(r);
        return DBIT'(v);
    endfunction

    // driver tasks
    task automatic send_byte(input logic [N-1:0] r, input logic o, input logic z, input bit push);
        @(negedge clk);
        alu_result = r;
        ovf        = o;
        zero       = z;
        send       = 1'b1;
        @(negedge clk);
        send = 1'b0;
        if (push) exp_q.push_back(model_byte(r, o, z));
        alu_result = ~r;
        ovf        = ~o;
        zero       = ~z;
    endtask

    task automatic recv_frame(input bit drop_send, output int t_start, output int t_done);
        int waited;
        int off;
        int d0;
        logic [DBIT-1:0] got;
        logic [DBIT-1:0] want;
        waited  = 0;
        t_start = 0;
        t_done  = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("start_seen", {31'd0, tx === 1'b0}, 32'd1);
        if (tx !== 1'b0) return;
        t_start = cyc;
        d0 = done_cnt;
        if (drop_send) send = 1'b0;
        repeat (BIT / 2 - 1) @(negedge clk);
        off = BIT / 2 - 1;
        check("start_bit", tx, 0);
        check("busy_mid", busy, 1);
        got = '0;
        for (int i = 0; i < DBIT; i++) begin
            repeat (BIT) @(negedge clk);
            off += BIT;
            got[i] = tx;
        end
        check("queue_nonempty", exp_q.size() > 0, 1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("data_byte", got, want);
`ifdef ALU_RESULT_TX_PARITY_EN
        repeat (BIT) @(negedge clk);
        off += BIT;
        check("parity_bit", tx, ^want);
`endif
        repeat (BIT) @(negedge clk);
        off += BIT;
        check("stop_bit", tx, 1);
        while (done !== 1'b1 && off < FRAME_LEN + 50) begin
            @(negedge clk);
            off++;
        end
        check("frame_len", off, FRAME_LEN);
        check("busy_at_done", busy, 0);
        check("no_early_done", done_cnt - d0, 0);
        t_done = cyc;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int ts;
        int td;
        int prev_done;
        int l0;
        int d0;
        logic [N-1:0] r;
        logic o;
        logic z;

        // reset
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        l0 = low_cnt;
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        check("rst_quiet_line", low_cnt - l0, 0);
        check("rst_quiet_done", done_cnt - d0, 0);

        // single frame 0x56; inputs flipped right after acceptance
        send_byte(5'b10110, 1'b1, 1'b0, 1'b1);
        recv_frame(1'b0, ts, td);

        // a second request during the frame is ignored
        d0 = done_cnt;
        fork
            begin
                send_byte(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'b1);
                recv_frame(1'b0, ts, td);
            end
            begin
                repeat (102) @(negedge clk);
                alu_result = 5'($urandom);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        l0 = low_cnt;
        repeat (400) @(negedge clk);
        check("ignored_line", low_cnt - l0, 0);
        check("ignored_done", done_cnt - d0, 1);

        // send held high: back-to-back frames, one idle cycle apart
        r = 5'($urandom_range(0, 31));
        o = 1'($urandom);
        z = 1'($urandom);
        @(negedge clk);
        alu_result = r;
        ovf = o;
        zero = z;
        send = 1'b1;
        for (int f = 0; f < 3; f++) exp_q.push_back(model_byte(r, o, z));
        d0 = done_cnt;
        prev_done = -1;
        for (int f = 0; f < 3; f++) begin
            recv_frame(f == 2, ts, td);
            if (prev_done >= 0) check("held_gap", ts - prev_done, 1);
            prev_done = td;
        end
        send = 1'b0;
        l0 = low_cnt;
        repeat (200) @(negedge clk);
        check("held_quiet", low_cnt - l0, 0);
        check("held_done_count", done_cnt - d0, 3);

        // reset during data bit 3 of 0x56 (that bit is 0)
        send_byte(5'b10110, 1'b1, 1'b0, 1'b0);
        repeat (4 * BIT + 10) @(negedge clk);
        check("pre_reset_bit3", tx, 0);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        l0 = low_cnt;
        repeat (50) @(negedge clk);
        check("abandon_no_done", done_cnt - d0, 0);
        check("abandon_quiet", low_cnt - l0, 0);
        send_byte(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'b1);
        recv_frame(1'b0, ts, td);

        // odd-parity data byte 0x01, then random frames
        send_byte(5'b00001, 1'b0, 1'b0, 1'b1);
        recv_frame(1'b0, ts, td);
        for (int k = 0; k < 4; k++) begin
            send_byte(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'b1);
            recv_frame(1'b0, ts, td);
        end
        check("queue_drained", exp_q.size(), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
